// File: rtl/puck_pkg.sv
// Shared types and table geometry for the puck physics engine and the
// field-drawing stages.
package puck_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    WALL,
    HIT,
    OUT,
    GOAL,
    SERVE
  } state_t;

  localparam int H_RES_DEF       = 1024;
  localparam int V_RES_DEF       = 768;
  localparam int GOAL_TOP_DEF    = 284;
  localparam int GOAL_BOTTOM_DEF = 484;

  localparam int POS_W = 12;
  localparam int VEL_W = 5;

endpackage

// File: rtl/puck_if.sv
// Frame sync, mallet positions in, puck position and status out.
interface puck_if;
  import puck_pkg::*;

  logic             vsync_in;
  logic [POS_W-1:0] xpos_l_in;
  logic [POS_W-1:0] ypos_l_in;
  logic [7:0]       radius_l_in;
  logic [POS_W-1:0] xpos_r_in;
  logic [POS_W-1:0] ypos_r_in;
  logic [7:0]       radius_r_in;
  logic [POS_W-1:0] xpos_out;
  logic [POS_W-1:0] ypos_out;
  logic             goal_l_out;
  logic             goal_r_out;
  logic             busy_out;

  modport master (
    output vsync_in, xpos_l_in, ypos_l_in, radius_l_in,
           xpos_r_in, ypos_r_in, radius_r_in,
    input  xpos_out, ypos_out, goal_l_out, goal_r_out, busy_out
  );

  modport slave (
    input  vsync_in, xpos_l_in, ypos_l_in, radius_l_in,
           xpos_r_in, ypos_r_in, radius_r_in,
    output xpos_out, ypos_out, goal_l_out, goal_r_out, busy_out
  );

endinterface

// File: rtl/puck_hit_check.sv
// Puck/mallet overlap test and the saturated rebound velocity it would give.
module puck_hit_check
  import puck_pkg::*;
#(
  parameter int PUCK_RADIUS = 16,
  parameter int SPEED_MAX   = 8
) (
  input  logic [POS_W-1:0]        px,
  input  logic [POS_W-1:0]        py,
  input  logic [POS_W-1:0]        xm,
  input  logic [POS_W-1:0]        ym,
  input  logic [7:0]              radius,
  output logic                    hit,
  output logic signed [VEL_W-1:0] cvx,
  output logic signed [VEL_W-1:0] cvy
);

  localparam logic signed [12:0] V_HI = 13'(SPEED_MAX);
  localparam logic signed [12:0] V_LO = -V_HI;

  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [12:0] v);
    if (v > V_HI) return V_HI[VEL_W-1:0];
    if (v < V_LO) return V_LO[VEL_W-1:0];
    return v[VEL_W-1:0];
  endfunction

  logic signed [12:0] dx;
  logic signed [12:0] dy;
  logic [11:0]        adx;
  logic [11:0]        ady;
  logic [8:0]         rsum;
  logic [25:0]        dist2;
  logic [25:0]        rsq;

  assign dx = $signed({1'b0, px}) - $signed({1'b0, xm});
  assign dy = $signed({1'b0, py}) - $signed({1'b0, ym});

  // Operands are both in 0..4095, so |d| always fits 12 bits.
  assign adx = dx[12] ? 12'(-dx) : dx[11:0];
  assign ady = dy[12] ? 12'(-dy) : dy[11:0];

  assign dist2 = 26'(adx) * 26'(adx) + 26'(ady) * 26'(ady);
  assign rsum  = 9'(PUCK_RADIUS) + 9'(radius);
  assign rsq   = 26'(rsum) * 26'(rsum);

  assign hit = (dist2 <= rsq);
  assign cvx = sat_vel(dx >>> 2);
  assign cvy = sat_vel(dy >>> 2);

endmodule

// File: rtl/puck_ctl.sv
// Per-frame puck physics: move, wall reflect / goal detect, mallet strike,
// then publish the new puck centre.
module puck_ctl
  import puck_pkg::*;
#(
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int PUCK_RADIUS  = 16,
  parameter int SPEED_MAX    = 8,
  parameter int GOAL_TOP     = GOAL_TOP_DEF,
  parameter int GOAL_BOTTOM  = GOAL_BOTTOM_DEF,
  parameter int SERVE_FRAMES = 60
) (
  input logic   clk_in,
  input logic   rst,
  puck_if.slave pif
);

  localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [POS_W-1:0] X_MIN  = POS_W'(PUCK_RADIUS);
  localparam logic [POS_W-1:0] X_MAX  = POS_W'(H_RES - 1 - PUCK_RADIUS);
  localparam logic [POS_W-1:0] Y_MIN  = POS_W'(PUCK_RADIUS);
  localparam logic [POS_W-1:0] Y_MAX  = POS_W'(V_RES - 1 - PUCK_RADIUS);
  localparam logic [POS_W-1:0] Y_GTOP = POS_W'(GOAL_TOP);
  localparam logic [POS_W-1:0] Y_GBOT = POS_W'(GOAL_BOTTOM);
  localparam logic [POS_W-1:0] X_CTR  = POS_W'(H_RES / 2);
  localparam logic [POS_W-1:0] Y_CTR  = POS_W'(V_RES / 2);

  localparam logic signed [VEL_W-1:0] V_MAX = VEL_W'(SPEED_MAX);

  state_t                  state;
  logic                    vsync_q;
  logic                    tick_q;
  logic [POS_W-1:0]        px;
  logic [POS_W-1:0]        py;
  logic signed [VEL_W-1:0] vx;
  logic signed [VEL_W-1:0] vy;
  logic [SERVE_W-1:0]      serve_cnt;
  logic [POS_W-1:0]        xpos_q;
  logic [POS_W-1:0]        ypos_q;
  logic                    goal_l_q;
  logic                    goal_r_q;
  logic                    busy_q;

  // Move step, 13-bit signed so a step past zero stays well defined.
  logic signed [12:0] mx;
  logic signed [12:0] my;

  assign mx = $signed({1'b0, px}) + 13'(vx);
  assign my = $signed({1'b0, py}) + 13'(vy);

  // Wall step: y clamp first, the goal mouth test uses the clamped y.
  logic [POS_W-1:0]        wy;
  logic signed [VEL_W-1:0] wvy;
  logic                    in_mouth;

  always_comb begin
    wy  = py;
    wvy = vy;
    if (py < Y_MIN) begin
      wy  = Y_MIN;
      wvy = -vy;
    end else if (py > Y_MAX) begin
      wy  = Y_MAX;
      wvy = -vy;
    end
  end

  assign in_mouth = (wy >= Y_GTOP) && (wy <= Y_GBOT);

  // Hit step
  logic                    hit_l;
  logic                    hit_r;
  logic signed [VEL_W-1:0] cvx_l;
  logic signed [VEL_W-1:0] cvy_l;
  logic signed [VEL_W-1:0] cvx_r;
  logic signed [VEL_W-1:0] cvy_r;
  logic                    hit_l_ok;
  logic                    hit_r_ok;
  logic signed [VEL_W-1:0] hvx;
  logic signed [VEL_W-1:0] hvy;

  puck_hit_check #(.PUCK_RADIUS(PUCK_RADIUS), .SPEED_MAX(SPEED_MAX)) u_hit_l (
    .px(px), .py(py), .xm(pif.xpos_l_in), .ym(pif.ypos_l_in), .radius(pif.radius_l_in),
    .hit(hit_l), .cvx(cvx_l), .cvy(cvy_l)
  );

  puck_hit_check #(.PUCK_RADIUS(PUCK_RADIUS), .SPEED_MAX(SPEED_MAX)) u_hit_r (
    .px(px), .py(py), .xm(pif.xpos_r_in), .ym(pif.ypos_r_in), .radius(pif.radius_r_in),
    .hit(hit_r), .cvx(cvx_r), .cvy(cvy_r)
  );

  // A mallet only strikes a puck that is not already moving away from it.
  assign hit_l_ok = hit_l && (vx[VEL_W-1] || (vx == '0));
  assign hit_r_ok = hit_r && !vx[VEL_W-1];

  always_comb begin
    hvx = vx;
    hvy = vy;
    if (hit_l_ok) begin
      if ((cvx_l == '0) && (cvy_l == '0)) begin
        hvx = V_MAX;
        hvy = '0;
      end else begin
        hvx = cvx_l;
        hvy = cvy_l;
      end
    end else if (hit_r_ok) begin
      if ((cvx_r == '0) && (cvy_r == '0)) begin
        hvx = -V_MAX;
        hvy = '0;
      end else begin
        hvx = cvx_r;
        hvy = cvy_r;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      tick_q    <= 1'b0;
      px        <= X_CTR;
      py        <= Y_CTR;
      vx        <= '0;
      vy        <= '0;
      serve_cnt <= '0;
      xpos_q    <= X_CTR;
      ypos_q    <= Y_CTR;
      goal_l_q  <= 1'b0;
      goal_r_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      vsync_q  <= pif.vsync_in;
      tick_q   <= pif.vsync_in & ~vsync_q;
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick_q) begin
            busy_q <= 1'b1;
            state  <= (serve_cnt != '0) ? SERVE : MOVE;
          end
        end
        MOVE: begin
          px    <= mx[POS_W-1:0];
          py    <= my[POS_W-1:0];
          state <= WALL;
        end
        WALL: begin
          py    <= wy;
          vy    <= wvy;
          state <= HIT;
          if (px < X_MIN) begin
            if (in_mouth) begin
              goal_r_q <= 1'b1;
              state    <= GOAL;
            end else begin
              px <= X_MIN;
              vx <= -vx;
            end
          end else if (px > X_MAX) begin
            if (in_mouth) begin
              goal_l_q <= 1'b1;
              state    <= GOAL;
            end else begin
              px <= X_MAX;
              vx <= -vx;
            end
          end
        end
        HIT: begin
          vx    <= hvx;
          vy    <= hvy;
          state <= OUT;
        end
        OUT: begin
          xpos_q <= px;
          ypos_q <= py;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        GOAL: begin
          px        <= X_CTR;
          py        <= Y_CTR;
          vx        <= '0;
          vy        <= '0;
          serve_cnt <= SERVE_W'(SERVE_FRAMES);
          xpos_q    <= X_CTR;
          ypos_q    <= Y_CTR;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        SERVE: begin
          serve_cnt <= serve_cnt - 1'b1;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign pif.xpos_out   = xpos_q;
  assign pif.ypos_out   = ypos_q;
  assign pif.goal_l_out = goal_l_q;
  assign pif.goal_r_out = goal_r_q;
  assign pif.busy_out   = busy_q;

endmodule

// File: tb/tb_puck_ctl.sv
// Directed bench for puck_ctl: frame latency, walls, goals, serve delay,
// mallet strikes and mid-frame reset.
module tb_puck_ctl;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  puck_if pif ();

  puck_ctl dut (
    .clk_in(clk_in),
    .rst   (rst),
    .pif   (pif)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_in);
    #2;
  endtask

  task automatic set_mallets(input int xl, input int yl, input int rl,
                             input int xr, input int yr, input int rr);
    pif.xpos_l_in   = 12'(xl);
    pif.ypos_l_in   = 12'(yl);
    pif.radius_l_in = 8'(rl);
    pif.xpos_r_in   = 12'(xr);
    pif.ypos_r_in   = 12'(yr);
    pif.radius_r_in = 8'(rr);
  endtask

  task automatic far_mallets();
    set_mallets(0, 0, 0, 0, 0, 0);
  endtask

  // Leaves the bench in cycle T with vsync_in high.
  task automatic start_frame();
    next_cyc();
    pif.vsync_in = 1'b1;
  endtask

  task automatic frame();
    start_frame();
    next_cyc();
    pif.vsync_in = 1'b0;
    repeat (6) next_cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) next_cyc();
    rst = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(pif.xpos_out), 32'(x));
    chk({tag, "_y"}, 32'(pif.ypos_out), 32'(y));
  endtask

  initial begin
    pif.vsync_in = 1'b0;
    far_mallets();
    repeat (3) next_cyc();
    chk_pos("reset_pos", 512, 384);
    chk("reset_goal_l", 32'(pif.goal_l_out), 0);
    chk("reset_goal_r", 32'(pif.goal_r_out), 0);
    chk("reset_busy", 32'(pif.busy_out), 0);
    rst = 1'b0;

    // First frame, cycle-by-cycle
    start_frame();
    next_cyc(); pif.vsync_in = 1'b0;
    chk("t1_busy", 32'(pif.busy_out), 0);
    next_cyc();
    chk("t2_busy", 32'(pif.busy_out), 1);
    next_cyc(); next_cyc();
    chk("t4_goal_l", 32'(pif.goal_l_out), 0);
    chk("t4_goal_r", 32'(pif.goal_r_out), 0);
    next_cyc();
    chk("t5_busy", 32'(pif.busy_out), 1);
    next_cyc();
    chk("t6_busy", 32'(pif.busy_out), 0);
    chk_pos("t6_pos", 512, 384);
    repeat (2) next_cyc();

    // Left strike from behind: dx=32 -> vx=+8
    set_mallets(480, 384, 20, 0, 0, 0);
    frame();
    chk_pos("strike_frame", 512, 384);
    far_mallets();
    start_frame();
    next_cyc(); pif.vsync_in = 1'b0;
    repeat (4) next_cyc();
    chk("strike_t5_x", 32'(pif.xpos_out), 512);
    next_cyc();
    chk("strike_t6_x", 32'(pif.xpos_out), 520);
    repeat (2) next_cyc();
    frame();
    chk_pos("strike_n2", 528, 384);
    frames(59);
    chk_pos("strike_n61", 1000, 384);

    // Right wall inside the goal mouth: left player scores
    start_frame();
    next_cyc(); pif.vsync_in = 1'b0;
    next_cyc(); next_cyc();
    chk("goal_l_t3", 32'(pif.goal_l_out), 0);
    next_cyc();
    chk("goal_l_t4", 32'(pif.goal_l_out), 1);
    chk("goal_l_t4_r", 32'(pif.goal_r_out), 0);
    chk("goal_l_t4_x", 32'(pif.xpos_out), 1000);
    next_cyc();
    chk("goal_l_t5", 32'(pif.goal_l_out), 0);
    chk_pos("goal_l_t5_pos", 512, 384);
    repeat (3) next_cyc();

    // Serve: 60 frames parked even with a mallet touching the puck
    set_mallets(480, 384, 20, 0, 0, 0);
    frames(30);
    chk_pos("serve_30", 512, 384);
    frames(30);
    chk_pos("serve_60", 512, 384);
    frame();
    chk_pos("serve_61", 512, 384);
    far_mallets();
    frame();
    chk_pos("serve_62", 520, 384);

    // Diagonal run: top wall reflection then left wall outside the mouth
    do_reset();
    set_mallets(0, 0, 0, 544, 416, 30);
    frame();
    chk_pos("diag_strike", 512, 384);
    far_mallets();
    frames(46);
    chk_pos("diag_n46", 144, 16);
    frame();
    chk_pos("diag_top_clamp", 136, 16);
    frame();
    chk_pos("diag_top_reflect", 128, 24);
    frames(14);
    chk_pos("diag_n62", 16, 136);
    start_frame();
    next_cyc(); pif.vsync_in = 1'b0;
    repeat (3) next_cyc();
    chk("side_t4_goal_l", 32'(pif.goal_l_out), 0);
    chk("side_t4_goal_r", 32'(pif.goal_r_out), 0);
    repeat (2) next_cyc();
    chk_pos("side_clamp", 16, 144);
    repeat (2) next_cyc();
    frame();
    chk_pos("side_reflect", 24, 152);

    // Both mallets touching: left takes priority
    do_reset();
    set_mallets(480, 384, 20, 544, 384, 20);
    frame();
    chk_pos("both_frame", 512, 384);
    far_mallets();
    frame();
    chk_pos("both_left_wins", 520, 384);

    // Same, with reset landing in the wall step
    do_reset();
    set_mallets(480, 384, 20, 544, 384, 20);
    start_frame();
    next_cyc(); pif.vsync_in = 1'b0;
    next_cyc(); next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    chk_pos("both_rst_pos", 512, 384);
    chk("both_rst_busy", 32'(pif.busy_out), 0);
    chk("both_rst_goal_l", 32'(pif.goal_l_out), 0);
    repeat (2) next_cyc();
    far_mallets();
    frame();
    chk_pos("both_rst_still", 512, 384);

    // Left wall inside the mouth: right player scores
    do_reset();
    set_mallets(0, 0, 0, 544, 384, 20);
    frame();
    far_mallets();
    frames(62);
    chk_pos("goal_r_n62", 16, 384);
    start_frame();
    next_cyc(); pif.vsync_in = 1'b0;
    repeat (3) next_cyc();
    chk("goal_r_t4", 32'(pif.goal_r_out), 1);
    chk("goal_r_t4_l", 32'(pif.goal_l_out), 0);
    next_cyc();
    chk("goal_r_t5", 32'(pif.goal_r_out), 0);
    chk_pos("goal_r_t5_pos", 512, 384);
    repeat (3) next_cyc();

    // Goal frame cut by reset: pulse dropped, serve counter cleared
    do_reset();
    set_mallets(0, 0, 0, 544, 384, 20);
    frame();
    far_mallets();
    frames(62);
    start_frame();
    next_cyc(); pif.vsync_in = 1'b0;
    next_cyc(); next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    chk("goal_rst_t4", 32'(pif.goal_r_out), 0);
    chk("goal_rst_busy", 32'(pif.busy_out), 0);
    chk_pos("goal_rst_pos", 512, 384);
    next_cyc();
    chk("goal_rst_t5", 32'(pif.goal_r_out), 0);
    repeat (2) next_cyc();
    set_mallets(480, 384, 20, 0, 0, 0);
    frame();
    far_mallets();
    frame();
    chk_pos("goal_rst_no_serve", 520, 384);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
